// File: rtl/rv32_fetch_unit.sv
// rv32 instruction fetch front-end: fetch PC, credit-limited memory requests, in-order refill queue.
// Optional misaligned-redirect trap enabled by defining RV32_FETCH_MISALIGN_TRAP_EN.
module rv32_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        rv32_clk,
  input  logic        rv32_rst_n,
  output logic [31:0] rv32_i_addr,
  output logic        rv32_i_req,
  input  logic        rv32_i_gnt,
  input  logic        rv32_i_rvalid,
  input  logic [31:0] rv32_i_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_trap
);

  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, HALT} state_e;
  state_e state_q, state_d;

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, alloc_q, fill_q;
  logic [CW-1:0] cnt_q, cnt_d, pend_q, pend_d, disc_q, disc_d;
  logic [CW:0]   credit_used;
  logic          filled_q   [FIFO_DEPTH];
  logic [31:0]   ent_pc_q   [FIFO_DEPTH];
  logic [31:0]   ent_data_q [FIFO_DEPTH];

  logic        issue, fill_we, drop, pop, redirect_misaligned;
  logic [31:0] redirect_target;

`ifdef RV32_FETCH_MISALIGN_TRAP_EN
  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign fetch_trap          = (state_q == HALT);
`else
  assign redirect_target     = redirect_pc & 32'hFFFF_FFFC;
  assign redirect_misaligned = 1'b0;
  assign fetch_trap          = 1'b0;
`endif

  assign instr_valid = filled_q[head_q];
  assign instr       = ent_data_q[head_q];
  assign instr_pc    = ent_pc_q[head_q];
  assign rv32_i_addr = pc_q;

  assign pop = instr_valid & instr_ready & ~redirect_valid;

  // A slot being popped this cycle is handed back immediately, otherwise a
  // 1-cycle memory could not sustain one instruction per cycle.
  assign credit_used = {1'b0, cnt_q} + {1'b0, disc_q} - (CW+1)'(pop);
  assign rv32_i_req  = rv32_rst_n & (state_q == RUN) & ~redirect_valid
                     & (credit_used < (CW+1)'(FIFO_DEPTH));

  assign issue   = rv32_i_req & rv32_i_gnt;
  assign drop    = rv32_i_rvalid & (disc_q != '0);
  assign fill_we = rv32_i_rvalid & (disc_q == '0) & (pend_q != '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q + CW'(issue) - CW'(pop);
    pend_d  = pend_q + CW'(issue) - CW'(fill_we);
    disc_d  = disc_q - CW'(drop);
    if (redirect_valid) begin
      state_d = redirect_misaligned ? HALT : RUN;
      pc_d    = redirect_target;
      cnt_d   = '0;
      pend_d  = '0;
      // Every outstanding allocation becomes a discard, except one whose word lands now.
      disc_d  = disc_q + pend_q - CW'(drop | fill_we);
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge rv32_clk) begin
    if (!rv32_rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      pend_q  <= '0;
      disc_q  <= '0;
      head_q  <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      disc_q  <= disc_d;
      if (redirect_valid) begin
        head_q  <= '0;
        alloc_q <= '0;
        fill_q  <= '0;
      end else begin
        if (issue)   alloc_q <= alloc_q + 1'b1;
        if (fill_we) fill_q  <= fill_q + 1'b1;
        if (pop)     head_q  <= head_q + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_ff @(posedge rv32_clk) begin
      if (!rv32_rst_n) begin
        filled_q[gi]   <= 1'b0;
        ent_pc_q[gi]   <= RESET_PC;
        ent_data_q[gi] <= NOP;
      end else begin
        if (redirect_valid)
          filled_q[gi] <= 1'b0;
        else if (fill_we && fill_q == AW'(gi))
          filled_q[gi] <= 1'b1;
        else if (pop && head_q == AW'(gi))
          filled_q[gi] <= 1'b0;
        if (issue && alloc_q == AW'(gi))
          ent_pc_q[gi] <= pc_q;
        if (fill_we && fill_q == AW'(gi))
          ent_data_q[gi] <= rv32_i_data;
      end
    end
  end

endmodule
